// File: rtl/keypad_press_model_if.sv
// Command handshake and row/column keypad bus between a press driver and the keypad press model.
// The model sits on the slave side. The scanner/test driver sits on the master side.
interface keypad_press_model_if #(
   parameter int KEYPAD_WIDTH = 4,
   parameter int HOLD_W       = 16
);
   logic [KEYPAD_WIDTH-1:0] row_n;
   logic [KEYPAD_WIDTH-1:0] col_n;
   logic                    cmd_valid;
   logic [3:0]              cmd_key;
   logic [HOLD_W-1:0]       cmd_hold;
   logic                    cmd_ready;
   logic                    contact;
   logic                    done;

   modport slave (
      input  row_n, cmd_valid, cmd_key, cmd_hold,
      output col_n, cmd_ready, contact, done
   );

   modport master (
      output row_n, cmd_valid, cmd_key, cmd_hold,
      input  col_n, cmd_ready, contact, done
   );
endinterface

// File: rtl/keypad_press_model.sv
// Keypad-side responder for a 4x4 row-scanned keypad.
// It replays one key press with contact bounce, a hold period and a release gap.
module keypad_press_model #(
   parameter int KEYPAD_WIDTH  = 4,
   parameter int HOLD_W        = 16,
   parameter int BOUNCE_CYCLES = 3,
   parameter int GAP_CYCLES    = 8
) (
   input  logic                clk,
   input  logic                rst_n,
   keypad_press_model_if.slave kp
);

   localparam int BG_MAX = (BOUNCE_CYCLES > GAP_CYCLES) ? BOUNCE_CYCLES : GAP_CYCLES;
   localparam int BG_W   = $clog2(BG_MAX + 1);
   localparam int CNT_W  = (HOLD_W > BG_W) ? HOLD_W : BG_W;

   localparam logic [CNT_W-1:0] B_LOAD = (BOUNCE_CYCLES > 0) ? CNT_W'(BOUNCE_CYCLES - 1) : '0;
   localparam logic [CNT_W-1:0] G_LOAD = (GAP_CYCLES > 0) ? CNT_W'(GAP_CYCLES - 1) : '0;

   typedef enum logic [2:0] {
      S_IDLE,
      S_BOUNCE_IN,
      S_HOLD,
      S_BOUNCE_OUT,
      S_GAP
   } state_t;

   state_t                  r_state;
   logic [CNT_W-1:0]        r_cnt;
   logic [HOLD_W-1:0]       r_hold;
   logic [KEYPAD_WIDTH-1:0] r_row_pat;
   logic [KEYPAD_WIDTH-1:0] r_col_pat;
   logic                    r_contact;
   logic                    r_done;

   logic                    w_accept;
   logic [HOLD_W-1:0]       w_hold_eff;
   logic [CNT_W-1:0]        w_hold_first;
   logic [CNT_W-1:0]        w_hold_reload;
   logic                    w_cnt_zero;
   logic [CNT_W-1:0]        w_cnt_dec;
   logic [KEYPAD_WIDTH-1:0] w_row_dec;
   logic [KEYPAD_WIDTH-1:0] w_col_dec;
   logic                    w_row_match;

   assign w_accept      = kp.cmd_valid && (r_state == S_IDLE);
   assign w_hold_eff    = (kp.cmd_hold == '0) ? HOLD_W'(1) : kp.cmd_hold;
   assign w_hold_first  = CNT_W'(w_hold_eff) - CNT_W'(1);
   assign w_hold_reload = CNT_W'(r_hold) - CNT_W'(1);
   assign w_cnt_zero    = (r_cnt == '0);
   assign w_cnt_dec     = w_cnt_zero ? '0 : r_cnt - CNT_W'(1);

   // Row index follows the physical layout: top row F E D C, bottom row 0 1 4 7.
   always_comb begin
      w_row_dec = 4'b1111;
      w_col_dec = 4'b1111;
      case (kp.cmd_key)
         4'hF: begin w_row_dec = 4'b0111; w_col_dec = 4'b0111; end
         4'hE: begin w_row_dec = 4'b0111; w_col_dec = 4'b1011; end
         4'hD: begin w_row_dec = 4'b0111; w_col_dec = 4'b1101; end
         4'hC: begin w_row_dec = 4'b0111; w_col_dec = 4'b1110; end
         4'hB: begin w_row_dec = 4'b1011; w_col_dec = 4'b0111; end
         4'h3: begin w_row_dec = 4'b1011; w_col_dec = 4'b1011; end
         4'h6: begin w_row_dec = 4'b1011; w_col_dec = 4'b1101; end
         4'h9: begin w_row_dec = 4'b1011; w_col_dec = 4'b1110; end
         4'hA: begin w_row_dec = 4'b1101; w_col_dec = 4'b0111; end
         4'h2: begin w_row_dec = 4'b1101; w_col_dec = 4'b1011; end
         4'h5: begin w_row_dec = 4'b1101; w_col_dec = 4'b1101; end
         4'h8: begin w_row_dec = 4'b1101; w_col_dec = 4'b1110; end
         4'h0: begin w_row_dec = 4'b1110; w_col_dec = 4'b0111; end
         4'h1: begin w_row_dec = 4'b1110; w_col_dec = 4'b1011; end
         4'h4: begin w_row_dec = 4'b1110; w_col_dec = 4'b1101; end
         4'h7: begin w_row_dec = 4'b1110; w_col_dec = 4'b1110; end
         default: begin w_row_dec = 4'b1111; w_col_dec = 4'b1111; end
      endcase
   end

   // r_cnt holds the cycles left in the current state after this one.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= S_IDLE;
         r_cnt     <= '0;
         r_hold    <= HOLD_W'(1);
         r_row_pat <= '1;
         r_col_pat <= '1;
         r_contact <= 1'b0;
         r_done    <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_hold    <= w_hold_eff;
                  r_row_pat <= w_row_dec;
                  r_col_pat <= w_col_dec;
                  r_contact <= 1'b1;
                  if (BOUNCE_CYCLES > 0) begin
                     r_state <= S_BOUNCE_IN;
                     r_cnt   <= B_LOAD;
                  end else begin
                     r_state <= S_HOLD;
                     r_cnt   <= w_hold_first;
                  end
               end
            end
            S_BOUNCE_IN: begin
               if (w_cnt_zero) begin
                  r_state   <= S_HOLD;
                  r_cnt     <= w_hold_reload;
                  r_contact <= 1'b1;
               end else begin
                  r_cnt     <= w_cnt_dec;
                  r_contact <= ~r_contact;
               end
            end
            S_HOLD: begin
               if (!w_cnt_zero) begin
                  r_cnt <= w_cnt_dec;
               end else if (BOUNCE_CYCLES > 0) begin
                  r_state   <= S_BOUNCE_OUT;
                  r_cnt     <= B_LOAD;
                  r_contact <= 1'b0;
               end else if (GAP_CYCLES > 0) begin
                  r_state   <= S_GAP;
                  r_cnt     <= G_LOAD;
                  r_contact <= 1'b0;
               end else begin
                  r_state   <= S_IDLE;
                  r_contact <= 1'b0;
                  r_done    <= 1'b1;
               end
            end
            S_BOUNCE_OUT: begin
               if (!w_cnt_zero) begin
                  r_cnt     <= w_cnt_dec;
                  r_contact <= ~r_contact;
               end else if (GAP_CYCLES > 0) begin
                  r_state   <= S_GAP;
                  r_cnt     <= G_LOAD;
                  r_contact <= 1'b0;
               end else begin
                  r_state   <= S_IDLE;
                  r_contact <= 1'b0;
                  r_done    <= 1'b1;
               end
            end
            S_GAP: begin
               if (w_cnt_zero) begin
                  r_state <= S_IDLE;
                  r_done  <= 1'b1;
               end else begin
                  r_cnt <= w_cnt_dec;
               end
            end
            default: begin
               r_state   <= S_IDLE;
               r_contact <= 1'b0;
            end
         endcase
      end
   end

   // Column readback answers the current row strobe in the same cycle.
   // The latched row has exactly one zero, so idle or multi-row strobes never match.
   assign w_row_match = r_contact && (kp.row_n == r_row_pat);

   genvar gi;
   generate
      for (gi = 0; gi < KEYPAD_WIDTH; gi++) begin : g_col
         assign kp.col_n[gi] = w_row_match ? r_col_pat[gi] : 1'b1;
      end
   endgenerate

   assign kp.cmd_ready = (r_state == S_IDLE);
   assign kp.contact   = r_contact;
   assign kp.done      = r_done;

endmodule

// File: tb/tb_keypad_press_model.sv
// Scoreboard bench for keypad_press_model: one instance without bounce, one with 3-cycle bounce.
// Both instances share command/row stimulus. Monitors check press traces on done and col_n on probes.
module tb_keypad_press_model;
   localparam int HOLD_W = 16;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              cmd_valid = 1'b0;
   logic [3:0]        cmd_key = 4'h0;
   logic [HOLD_W-1:0] cmd_hold = '0;
   logic [3:0]        row_n = 4'b1111;

   always #10 clk = ~clk;

   keypad_press_model_if #(.KEYPAD_WIDTH(4), .HOLD_W(HOLD_W)) if0 ();
   keypad_press_model_if #(.KEYPAD_WIDTH(4), .HOLD_W(HOLD_W)) if3 ();

   assign if0.cmd_valid = cmd_valid;
   assign if0.cmd_key   = cmd_key;
   assign if0.cmd_hold  = cmd_hold;
   assign if0.row_n     = row_n;
   assign if3.cmd_valid = cmd_valid;
   assign if3.cmd_key   = cmd_key;
   assign if3.cmd_hold  = cmd_hold;
   assign if3.row_n     = row_n;

   keypad_press_model #(.KEYPAD_WIDTH(4), .HOLD_W(HOLD_W), .BOUNCE_CYCLES(0), .GAP_CYCLES(8)) dut0 (
      .clk   (clk),
      .rst_n (rst_n),
      .kp    (if0)
   );

   keypad_press_model #(.KEYPAD_WIDTH(4), .HOLD_W(HOLD_W), .BOUNCE_CYCLES(3), .GAP_CYCLES(8)) dut3 (
      .clk   (clk),
      .rst_n (rst_n),
      .kp    (if3)
   );

   typedef struct {
      logic [63:0] trace;
      int          cnt;
   } seq_t;

   typedef struct {
      logic [3:0] col;
      logic [3:0] row;
      int         key;
   } col_t;

   seq_t q0[$];
   seq_t q3[$];
   col_t cq[$];
   int   n_cmp = 0;
   int   n_fail = 0;
   event probe_ev;

   logic [3:0] key_row [16] = '{4'b1110, 4'b1110, 4'b1101, 4'b1011, 4'b1110, 4'b1101, 4'b1011, 4'b1110,
                                4'b1101, 4'b1011, 4'b1101, 4'b1011, 4'b0111, 4'b0111, 4'b0111, 4'b0111};
   logic [3:0] key_col [16] = '{4'b0111, 4'b1011, 4'b1011, 4'b1011, 4'b1101, 4'b1101, 4'b1101, 4'b1110,
                                4'b1110, 4'b1110, 4'b0111, 4'b0111, 4'b1110, 4'b1101, 4'b1011, 4'b0111};
   logic [3:0] rows [6] = '{4'b0111, 4'b1011, 4'b1101, 4'b1110, 4'b1111, 4'b0000};

   // Trace is the contact value of every cycle from the one after accept up to done, oldest in the MSBs.
   logic [63:0] tr0, tr3;
   int          cnt0, cnt3;
   bit          act0, act3;

   always @(negedge clk) begin
      seq_t e;
      if (!rst_n) begin
         act0 = 1'b0;
      end else begin
         if (if0.done) begin
            n_cmp++;
            if (q0.size() == 0) begin
               n_fail++;
               $display("FAIL dut0_unexpected_done got done=1 required no done");
            end else begin
               e = q0.pop_front();
               if (e.cnt != cnt0 || e.trace != tr0) begin
                  n_fail++;
                  $display("FAIL dut0_seq got cnt=%0d trace=%b required cnt=%0d trace=%b", cnt0, tr0, e.cnt, e.trace);
               end else begin
                  $display("dut0 seq ok cnt=%0d trace=%b", cnt0, tr0);
               end
            end
            n_cmp++;
            if (if0.cmd_ready !== 1'b1) begin
               n_fail++;
               $display("FAIL dut0_ready_in_done got %b required 1", if0.cmd_ready);
            end
            act0 = 1'b0;
         end
         if (cmd_valid && if0.cmd_ready) begin
            act0 = 1'b1; cnt0 = 0; tr0 = '0;
         end else if (act0) begin
            tr0 = {tr0[62:0], if0.contact}; cnt0++;
         end
      end
   end

   always @(negedge clk) begin
      seq_t e;
      if (!rst_n) begin
         act3 = 1'b0;
      end else begin
         if (if3.done) begin
            n_cmp++;
            if (q3.size() == 0) begin
               n_fail++;
               $display("FAIL dut3_unexpected_done got done=1 required no done");
            end else begin
               e = q3.pop_front();
               if (e.cnt != cnt3 || e.trace != tr3) begin
                  n_fail++;
                  $display("FAIL dut3_seq got cnt=%0d trace=%b required cnt=%0d trace=%b", cnt3, tr3, e.cnt, e.trace);
               end else begin
                  $display("dut3 seq ok cnt=%0d trace=%b", cnt3, tr3);
               end
            end
            n_cmp++;
            if (if3.cmd_ready !== 1'b1) begin
               n_fail++;
               $display("FAIL dut3_ready_in_done got %b required 1", if3.cmd_ready);
            end
            act3 = 1'b0;
         end
         if (cmd_valid && if3.cmd_ready) begin
            act3 = 1'b1; cnt3 = 0; tr3 = '0;
         end else if (act3) begin
            tr3 = {tr3[62:0], if3.contact}; cnt3++;
         end
      end
   end

   always @(probe_ev) begin
      col_t c;
      n_cmp++;
      if (cq.size() == 0) begin
         n_fail++;
         $display("FAIL col_probe_empty got col_n=%b required queued entry", if0.col_n);
      end else begin
         c = cq.pop_front();
         if (if0.col_n !== c.col) begin
            n_fail++;
            $display("FAIL col_key%0h_row%b got col_n=%b required %b", c.key, c.row, if0.col_n, c.col);
         end else begin
            $display("col key=%0h row=%b col_n=%b ok", c.key, c.row, if0.col_n);
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h required=%0h", name, act, exp);
      end else begin
         $display("%s ok value=%0h", name, act);
      end
   endtask

   task automatic probe(input logic [3:0] r, input logic [3:0] exp, input int key);
      row_n = r;
      #1;
      cq.push_back('{col: exp, row: r, key: key});
      -> probe_ev;
      #1;
   endtask

   // Hand-computed contact traces: no-bounce unit, then 3-cycle-bounce unit; 8 gap zeros each.
   task automatic push_exp(input int h);
      seq_t e0, e3;
      case (h)
         0, 1: begin
            e0 = '{trace: 64'b1_00000000, cnt: 9};
            e3 = '{trace: 64'b101_1_010_00000000, cnt: 15};
         end
         2: begin
            e0 = '{trace: 64'b11_00000000, cnt: 10};
            e3 = '{trace: 64'b101_11_010_00000000, cnt: 16};
         end
         4: begin
            e0 = '{trace: 64'b1111_00000000, cnt: 12};
            e3 = '{trace: 64'b101_1111_010_00000000, cnt: 18};
         end
         default: begin
            e0 = '{trace: 64'b11111111_00000000, cnt: 16};
            e3 = '{trace: 64'b101_11111111_010_00000000, cnt: 22};
         end
      endcase
      q0.push_back(e0);
      q3.push_back(e3);
   endtask

   task automatic wait_ready();
      bit ok = 1'b0;
      for (int i = 0; i < 400; i++) begin
         @(posedge clk);
         #1;
         if (if0.cmd_ready && if3.cmd_ready) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) begin
         n_cmp++; n_fail++;
         $display("FAIL wait_ready_timeout got ready0=%b ready3=%b required 1 1", if0.cmd_ready, if3.cmd_ready);
      end
   endtask

   task automatic issue(input logic [3:0] key, input int hold, input bit push);
      if (push) push_exp(hold);
      cmd_key   = key;
      cmd_hold  = HOLD_W'(hold);
      cmd_valid = 1'b1;
      @(posedge clk);
      #1 cmd_valid = 1'b0;
   endtask

   initial begin
      #2000000;
      $display("FAIL global_timeout got running required finished");
      $fatal(1, "timeout");
   end

   initial begin
      bit seen;
      repeat (3) @(posedge clk);
      #3 rst_n = 1'b1;
      @(posedge clk);
      #5;
      chk("reset_ready0", 32'(if0.cmd_ready), 32'd1);
      chk("reset_ready3", 32'(if3.cmd_ready), 32'd1);
      chk("reset_contact0", 32'(if0.contact), 32'd0);
      chk("reset_done3", 32'(if3.done), 32'd0);
      chk("reset_col3", 32'(if3.col_n), 32'hF);
      probe(4'b1110, 4'b1111, 0);
      row_n = 4'b1111;

      // Basic press of key 5 with a busy-time command that must be ignored.
      wait_ready();
      issue(4'h5, 8, 1'b1);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1 cmd_valid = 1'b1; cmd_key = 4'h3; cmd_hold = HOLD_W'(2);
         #4;
         chk("busy_ready0", 32'(if0.cmd_ready), 32'd0);
         chk("busy_ready3", 32'(if3.cmd_ready), 32'd0);
      end
      probe(4'b1101, 4'b1101, 5);
      probe(4'b1011, 4'b1111, 5);
      probe(4'b0000, 4'b1111, 5);
      @(posedge clk);
      #1 cmd_valid = 1'b0; row_n = 4'b1111;

      wait_ready();
      issue(4'h0, 0, 1'b1);
      wait_ready();
      issue(4'hE, 4, 1'b1);
      wait_ready();
      issue(4'h1, 2, 1'b1);

      // Full key map: one single-cycle press per key, all row strobes swept inside that cycle.
      for (int k = 0; k < 16; k++) begin
         wait_ready();
         issue(4'(k), 1, 1'b1);
         for (int r = 0; r < 6; r++) begin
            probe(rows[r], (rows[r] == key_row[k]) ? key_col[k] : 4'b1111, k);
         end
         row_n = 4'b1111;
      end

      // Back-to-back: cmd_valid stays high so each unit re-accepts in its done cycle.
      wait_ready();
      push_exp(8);
      push_exp(8);
      cmd_key = 4'h2; cmd_hold = HOLD_W'(8); cmd_valid = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(posedge clk);
         #5;
         if (if3.done) begin
            seen = 1'b1;
            break;
         end
      end
      if (!seen) begin
         n_cmp++; n_fail++;
         $display("FAIL b2b_done_timeout got no done required done");
      end
      @(posedge clk);
      #1 cmd_valid = 1'b0;

      // Asynchronous reset in the middle of HOLD: no done may follow.
      wait_ready();
      issue(4'h9, 20, 1'b0);
      row_n = 4'b1011;
      repeat (5) @(posedge clk);
      #5;
      probe(4'b1011, 4'b1110, 9);
      rst_n = 1'b0;
      #1;
      chk("rst_contact0", 32'(if0.contact), 32'd0);
      chk("rst_contact3", 32'(if3.contact), 32'd0);
      chk("rst_col0", 32'(if0.col_n), 32'hF);
      chk("rst_ready0", 32'(if0.cmd_ready), 32'd1);
      @(posedge clk);
      #3 rst_n = 1'b1;
      row_n = 4'b1111;
      repeat (40) @(posedge clk);
      #5;
      chk("post_rst_ready0", 32'(if0.cmd_ready), 32'd1);
      chk("post_rst_ready3", 32'(if3.cmd_ready), 32'd1);

      wait_ready();
      repeat (3) @(posedge clk);
      chk("q0_drained", 32'(q0.size()), 32'd0);
      chk("q3_drained", 32'(q3.size()), 32'd0);
      chk("cq_drained", 32'(cq.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
